// File: rtl/clock_divider_bank_pkg.sv
// Shared constants and types for the clock divider bank: product default divisors,
// audio tone half-periods and the per-channel operating mode.
package clock_divider_bank_pkg;

   localparam int CLKDIV_NUM_CH = 4;
   localparam int CLKDIV_DIV_W  = 26;

   // Half-periods in 40 MHz system clock cycles
   localparam int DIV_BY_20M    = 20_000_000;   // 1 Hz
   localparam int DIV_BY_20M_W  = 25;
   localparam int DIV_BY_200K   = 200_000;      // 100 Hz
   localparam int DIV_BY_200K_W = 18;

   localparam int TONE_C5_HALF  = 38_223;       // 523.25 Hz
   localparam int TONE_A4_HALF  = 45_455;       // 440 Hz
   localparam int TONE_A5_HALF  = 22_727;       // 880 Hz

   typedef enum logic [1:0] {
      MODE_RUN  = 2'd0,
      MODE_HOLD = 2'd1,
      MODE_SYNC = 2'd2
   } ch_mode_e;

   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clock_divider_bank_if.sv
// Control/status bundle between a divider bank and its owner.
interface clock_divider_bank_if
   import clock_divider_bank_pkg::*;
#(
   parameter int NUM_CH = CLKDIV_NUM_CH,
   parameter int DIV_W  = CLKDIV_DIV_W,
   parameter int CH_W   = ch_idx_w(NUM_CH)
);
   logic [NUM_CH-1:0] en;
   logic              sync;
   logic              wr_en;
   logic [CH_W-1:0]   wr_ch;
   logic [DIV_W-1:0]  wr_half;
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   modport master (
      output en, sync, wr_en, wr_ch, wr_half,
      input  pend, clk_out, tick
   );

   modport slave (
      input  en, sync, wr_en, wr_ch, wr_half,
      output pend, clk_out, tick
   );
endinterface

// File: rtl/clock_divider_bank_channel.sv
// One square-wave divider: half-period counter, active/shadow divisor and pending flag.
// mode      | meaning
// MODE_RUN  | counting; toggles clk_out at the end of each half-period
// MODE_HOLD | disabled; counter and output parked at 0
// MODE_SYNC | global phase restart; counter and output parked at 0
module clk_div_channel
   import clock_divider_bank_pkg::*;
#(
   parameter int               DIV_W   = CLKDIV_DIV_W,
   parameter logic [DIV_W-1:0] DEF_VAL = DIV_W'(DIV_BY_20M)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             ld,
   input  logic [DIV_W-1:0] ld_val,
   output logic             pend,
   output logic             clk_out,
   output logic             tick
);

   ch_mode_e         mode;
   logic [DIV_W-1:0] cnt, cnt_nxt;
   logic [DIV_W-1:0] half, half_nxt;
   logic [DIV_W-1:0] shadow, shadow_nxt;
   logic [DIV_W-1:0] h_eff;
   logic             term, apply;
   logic             pend_nxt, clk_nxt, tick_nxt;

   always_comb begin
      h_eff = (half == '0) ? DIV_W'(1) : half;
      term  = (cnt == h_eff - DIV_W'(1));

      if (sync)     mode = MODE_SYNC;
      else if (!en) mode = MODE_HOLD;
      else          mode = MODE_RUN;

      cnt_nxt  = cnt + DIV_W'(1);
      clk_nxt  = clk_out;
      tick_nxt = 1'b0;
      apply    = 1'b0;

      unique case (mode)
         MODE_SYNC, MODE_HOLD: begin
            cnt_nxt = '0;
            clk_nxt = 1'b0;
            apply   = pend;
         end
         MODE_RUN: begin
            // Divisor swaps only at a half-period boundary, so no runt pulses
            if (term) begin
               cnt_nxt  = '0;
               clk_nxt  = ~clk_out;
               tick_nxt = ~clk_out;
               apply    = pend;
            end
         end
         default: ;
      endcase

      // An apply consumes the pre-edge shadow; a same-cycle write re-arms pend
      half_nxt   = apply ? shadow : half;
      shadow_nxt = ld ? ld_val : shadow;
      pend_nxt   = ld | (pend & ~apply);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         half    <= DEF_VAL;
         shadow  <= DEF_VAL;
         pend    <= 1'b0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         half    <= half_nxt;
         shadow  <= shadow_nxt;
         pend    <= pend_nxt;
         clk_out <= clk_nxt;
         tick    <= tick_nxt;
      end
   end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent square-wave dividers with runtime-loadable half-periods.
// Top level only decodes the divisor write and hands each channel its reset divisor.
module clock_divider_bank
   import clock_divider_bank_pkg::*;
#(
   parameter int                      NUM_CH   = CLKDIV_NUM_CH,
   parameter int                      DIV_W    = CLKDIV_DIV_W,
   parameter logic [NUM_CH*DIV_W-1:0] DEF_HALF = {CLKDIV_NUM_CH{26'(DIV_BY_20M)}}
) (
   input  logic              clk,
   input  logic              rst,
   clock_divider_bank_if.slave bus
);

   localparam int CH_W = ch_idx_w(NUM_CH);

   logic [NUM_CH-1:0] ld;

   // Out-of-range channel indices match no channel and are dropped
   always_comb begin
      ld = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ld[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_channel #(
         .DIV_W   (DIV_W),
         .DEF_VAL (DEF_HALF[g*DIV_W +: DIV_W])
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .en      (bus.en[g]),
         .sync    (bus.sync),
         .ld      (ld[g]),
         .ld_val  (bus.wr_half),
         .pend    (bus.pend[g]),
         .clk_out (bus.clk_out[g]),
         .tick    (bus.tick[g])
      );
   end

endmodule
